// File: rtl/pb_entry_pkg.sv
// Shared types and constants for the pushbutton hex-entry front end.
package pb_entry_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } entry_state_t;

  localparam int KEY_BKSP   = 16;
  localparam int KEY_ENTER  = 17;
  localparam int NUM_KEYS   = 18;
  localparam int MAX_DIGITS = 8;

  // Nibble value of the (single) hex key set in k; 0 when none is set.
  function automatic logic [3:0] hex_of(input logic [15:0] k);
    hex_of = '0;
    for (int i = 0; i < 16; i++)
      if (k[i]) hex_of = 4'(i);
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// Two-flop synchronizer plus stability counter; strobes once when a new
// input pattern has held for DEBOUNCE_CYCLES samples.
module pb_debounce #(
  parameter int WIDTH           = 18,
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             stable_edge
);

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0] CNT_QUAL = 4'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1, k, k_prev;
  logic [3:0]       cnt;
  logic [1:0]       warm;

  // warm holds off qualification until the synchronizer carries real
  // input, so the zeros flushed in by reset never count as a release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      k      <= '0;
      k_prev <= '0;
      cnt    <= '0;
      warm   <= '0;
    end else begin
      sync1  <= raw;
      k      <= sync1;
      k_prev <= k;
      warm   <= {warm[0], 1'b1};
      if (!warm[1] || k != k_prev)
        cnt <= '0;
      else if (cnt < CNT_MAX)
        cnt <= cnt + 4'd1;
    end
  end

  assign stable      = k;
  assign stable_edge = warm[1] && (k == k_prev) && (cnt == CNT_QUAL);

endmodule

// File: rtl/pb_hex_entry.sv
// Hex keypad entry: debounced key events build a 32-bit word, submitted to
// the core over valid/ready; the in-progress word is exported for display.
module pb_hex_entry
  import pb_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic [20:0] pb,
  output logic [31:0] entry,
  output logic [3:0]  digit_count,
  output logic [31:0] data,
  output logic        valid,
  input  logic        ready
);

  logic [NUM_KEYS-1:0] k;
  logic                stable_edge;
  logic                unused_pb;

  assign unused_pb = ^pb[20:18];

  pb_debounce #(
    .WIDTH          (NUM_KEYS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (hz100),
    .rst        (reset),
    .raw        (pb[NUM_KEYS-1:0]),
    .stable     (k),
    .stable_edge(stable_edge)
  );

  entry_state_t state, next_state;
  logic         armed;
  logic         fire;
  logic         is_bksp, is_enter;
  logic [3:0]   nibble;

  // armed is clear until the first qualification after reset; a key still
  // held across reset lands in PRESSED without firing.
  always_comb begin
    next_state = state;
    fire       = 1'b0;
    case (state)
      IDLE:
        if (stable_edge && |k) begin
          next_state = PRESSED;
          fire       = armed && !valid && $onehot(k);
        end
      PRESSED:
        if (stable_edge && k == '0)
          next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign is_bksp  = k[KEY_BKSP];
  assign is_enter = k[KEY_ENTER];
  assign nibble   = hex_of(k[15:0]);

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= next_state;
      armed <= armed | stable_edge;
    end
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      entry       <= '0;
      digit_count <= '0;
      data        <= '0;
      valid       <= 1'b0;
    end else if (valid && ready) begin
      valid       <= 1'b0;
      entry       <= '0;
      digit_count <= '0;
    end else if (fire) begin
      if (is_enter) begin
        data  <= entry;
        valid <= 1'b1;
      end else if (is_bksp) begin
        entry <= entry >> 4;
        if (digit_count != '0)
          digit_count <= digit_count - 4'd1;
      end else begin
        entry <= {entry[27:0], nibble};
        if (digit_count != 4'(MAX_DIGITS))
          digit_count <= digit_count + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_pb_hex_entry.sv
// Bench for pb_hex_entry: directed scenarios plus randomized key traffic
// against a digit-queue reference model.
module tb_pb_hex_entry;
  localparam int D = 2;

  logic        hz100 = 1'b0;
  logic        reset = 1'b1;
  logic [20:0] pb    = '0;
  logic        ready = 1'b0;
  logic [31:0] entry, data;
  logic [3:0]  digit_count;
  logic        valid;

  pb_hex_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .hz100      (hz100),
    .reset      (reset),
    .pb         (pb),
    .entry      (entry),
    .digit_count(digit_count),
    .data       (data),
    .valid      (valid),
    .ready      (ready)
  );

  always #5 hz100 = ~hz100;

  int passed = 0;
  int total  = 0;

  // Reference model: typed digits oldest-first, plus the handshake register.
  logic [3:0]  mq[$];
  logic [31:0] mdata  = '0;
  logic        mvalid = 1'b0;

  localparam logic [20:0] BKSP  = 21'(1) << 16;
  localparam logic [20:0] ENTER = 21'(1) << 17;

  function automatic logic [31:0] m_entry();
    logic [31:0] v = '0;
    foreach (mq[i]) v = {v[27:0], mq[i]};
    return v;
  endfunction

  function automatic void m_press(input logic [17:0] kk);
    if (mvalid || !$onehot(kk)) return;
    if (kk[17]) begin
      mdata  = m_entry();
      mvalid = 1'b1;
    end else if (kk[16]) begin
      if (mq.size() > 0) void'(mq.pop_back());
    end else begin
      for (int i = 0; i < 16; i++)
        if (kk[i]) mq.push_back(4'(i));
      if (mq.size() > 8) void'(mq.pop_front());
    end
  endfunction

  function automatic void m_ack();
    if (mvalid) begin
      mvalid = 1'b0;
      mq.delete();
    end
  endfunction

  function automatic logic [20:0] hex(input int h);
    return 21'(1) << h;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge hz100);
  endtask

  task automatic tap(input logic [20:0] p, input int h, input int gap);
    pb = p;
    cyc(h);
    pb = '0;
    cyc(gap);
    m_press(p[17:0]);
  endtask

  task automatic ack();
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    m_ack();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pb    = '0;
    ready = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(10);
    mq.delete();
    mvalid = 1'b0;
    mdata  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    total++; if (entry !== 32'h0) $display("FAIL reset_entry: got %h want 0", entry); else passed++;
    total++; if (digit_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", digit_count); else passed++;
    total++; if (data !== 32'h0) $display("FAIL reset_data: got %h want 0", data); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else passed++;
    do_reset();
  endtask

  task automatic test_latency();
    do_reset();
    pb = hex(12);
    cyc(D + 2);
    total++; if (entry !== 32'h0) $display("FAIL latency_early: got %h want 0", entry); else passed++;
    cyc(1);
    total++; if (entry !== 32'hC) $display("FAIL latency_edge: got %h want c", entry); else passed++;
    cyc(10);
    pb = '0;
    cyc(8);
    total++; if (entry !== 32'hC || digit_count !== 4'd1)
      $display("FAIL latency_hold: got %h/%0d want c/1", entry, digit_count); else passed++;
  endtask

  task automatic test_sequence();
    do_reset();
    tap(hex(1), 5, 8);
    tap(hex(2), 5, 8);
    tap(hex(10), 5, 8);
    tap(hex(15), 5, 8);
    total++; if (entry !== 32'h12AF) $display("FAIL seq_entry: got %h want 12af", entry); else passed++;
    total++; if (digit_count !== 4'd4) $display("FAIL seq_count: got %0d want 4", digit_count); else passed++;
    tap(ENTER, 5, 8);
    total++; if (valid !== 1'b1 || data !== 32'h12AF)
      $display("FAIL seq_submit: got %b/%h want 1/12af", valid, data); else passed++;
    cyc(40);
    total++; if (valid !== 1'b1) $display("FAIL seq_hold_valid: got %b want 1", valid); else passed++;
    ack();
    total++; if (valid !== 1'b0) $display("FAIL seq_ack_valid: got %b want 0", valid); else passed++;
    total++; if (entry !== 32'h0 || digit_count !== 4'd0)
      $display("FAIL seq_ack_clear: got %h/%0d want 0/0", entry, digit_count); else passed++;
    total++; if (data !== 32'h12AF) $display("FAIL seq_ack_data: got %h want 12af", data); else passed++;
  endtask

  task automatic test_overflow_bksp();
    do_reset();
    for (int i = 0; i < 10; i++) tap(hex(i), 5, 8);
    total++; if (entry !== 32'h23456789 || digit_count !== 4'd8)
      $display("FAIL overflow: got %h/%0d want 23456789/8", entry, digit_count); else passed++;
    for (int i = 0; i < 3; i++) tap(BKSP, 5, 8);
    total++; if (entry !== 32'h00023456 || digit_count !== 4'd5)
      $display("FAIL backspace: got %h/%0d want 00023456/5", entry, digit_count); else passed++;
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pb = (i % 2 == 0) ? hex(5) : '0;
      cyc(1);
    end
    pb = hex(5);
    cyc(4);
    pb = '0;
    cyc(8);
    total++; if (entry !== 32'h5 || digit_count !== 4'd1)
      $display("FAIL bounce: got %h/%0d want 5/1", entry, digit_count); else passed++;
    tap(hex(5), 50, 8);
    total++; if (entry !== 32'h55 || digit_count !== 4'd2)
      $display("FAIL long_hold: got %h/%0d want 55/2", entry, digit_count); else passed++;
  endtask

  task automatic test_ignored();
    do_reset();
    tap(hex(3) | hex(4), 6, 8);
    total++; if (entry !== 32'h0 || digit_count !== 4'd0)
      $display("FAIL multi_key: got %h/%0d want 0/0", entry, digit_count); else passed++;
    tap(BKSP, 6, 8);
    total++; if (entry !== 32'h0 || digit_count !== 4'd0)
      $display("FAIL bksp_empty: got %h/%0d want 0/0", entry, digit_count); else passed++;
    tap(hex(1), 6, 8);
    tap(hex(3) | hex(4), 6, 8);
    total++; if (entry !== 32'h1) $display("FAIL multi_key_kept: got %h want 1", entry); else passed++;
    tap(ENTER, 6, 8);
    tap(hex(7), 6, 8);
    total++; if (entry !== 32'h1 || valid !== 1'b1 || data !== 32'h1)
      $display("FAIL key_while_valid: got %h/%b/%h want 1/1/1", entry, valid, data); else passed++;
    ack();
    cyc(20);
    total++; if (entry !== 32'h0 || digit_count !== 4'd0 || valid !== 1'b0)
      $display("FAIL no_latched_event: got %h/%0d/%b want 0/0/0", entry, digit_count, valid); else passed++;
  endtask

  task automatic test_reset_held();
    do_reset();
    tap(hex(2), 5, 8);
    pb = hex(9);
    cyc(D + 6);
    total++; if (entry !== 32'h29) $display("FAIL held_pre_reset: got %h want 29", entry); else passed++;
    reset = 1'b1;
    #1;
    total++; if (entry !== 32'h0 || digit_count !== 4'd0 || valid !== 1'b0 || data !== 32'h0)
      $display("FAIL async_reset: got %h/%0d/%b/%h want all 0", entry, digit_count, valid, data); else passed++;
    cyc(1);
    reset = 1'b0;
    cyc(30);
    total++; if (entry !== 32'h0 || digit_count !== 4'd0)
      $display("FAIL held_after_reset: got %h/%0d want 0/0", entry, digit_count); else passed++;
    pb = '0;
    cyc(8);
    mq.delete();
    mvalid = 1'b0;
    mdata  = '0;
    tap(hex(9), 5, 8);
    total++; if (entry !== 32'h9 || digit_count !== 4'd1)
      $display("FAIL repress_after_reset: got %h/%0d want 9/1", entry, digit_count); else passed++;
  endtask

  task automatic test_random();
    logic [20:0] p;
    int          r, a, b;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 10);
      repeat ($urandom_range(0, 3)) begin
        pb = 21'($urandom);
        cyc(1);
        pb = '0;
        cyc(1);
      end
      if (r == 9 && mvalid) begin
        ready = 1'b1;
        cyc($urandom_range(1, 4));
        ready = 1'b0;
        m_ack();
      end else if (r == 10) begin
        ready = 1'b1;
        m_ack();
        tap({3'($urandom), ENTER[17:0]}, $urandom_range(D + 2, 12), $urandom_range(D + 4, 10));
        m_ack();
        ready = 1'b0;
      end else begin
        if (r <= 5 || r == 9) p = hex($urandom_range(0, 15));
        else if (r == 6) p = BKSP;
        else if (r == 7) p = ENTER;
        else begin
          a = $urandom_range(0, 17);
          b = (a + $urandom_range(1, 17)) % 18;
          p = hex(a) | hex(b);
        end
        p[20:18] = 3'($urandom);
        tap(p, $urandom_range(D + 2, 12), $urandom_range(D + 4, 10));
      end
      total++; if (entry !== m_entry()) $display("FAIL rnd_entry[%0d]: got %h want %h", it, entry, m_entry()); else passed++;
      total++; if (digit_count !== 4'(mq.size())) $display("FAIL rnd_count[%0d]: got %0d want %0d", it, digit_count, mq.size()); else passed++;
      total++; if (valid !== mvalid) $display("FAIL rnd_valid[%0d]: got %b want %b", it, valid, mvalid); else passed++;
      total++; if (data !== mdata) $display("FAIL rnd_data[%0d]: got %h want %h", it, data, mdata); else passed++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_sequence();
    test_overflow_bksp();
    test_bounce();
    test_ignored();
    test_reset_held();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
